// File: rtl/lzc_pipe.sv
// ---------------------------------------------------------------------------
// lzc_pipe
// Pipelined leading-zero / leading-one counter for the ALU CLZ/CLO path.
// A binary search resolves one count bit per registered stage, so the unit
// has a latency of $clog2(WIDTH) cycles and accepts one operand per cycle.
// A sideband tag travels with each operand so results can be matched to rd.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous kill of every in-flight operation
//   in_valid   operand present
//   in_ready   unit accepts an operand this cycle (= no output stall)
//   in_data    operand, WIDTH bits
//   in_mode    0 = count leading zeros, 1 = count leading ones
//   in_tag     sideband tag, returned unchanged with the result
//   out_valid  result present
//   out_ready  consumer takes the result this cycle
//   out_count  leading count, 0..WIDTH
//   out_all    operand consisted entirely of the counted bit
//   out_tag    tag of this result
// ---------------------------------------------------------------------------
module lzc_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    localparam int CW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_all,
    output logic [TAG_W-1:0] out_tag
);

    localparam int L = $clog2(WIDTH);

    logic             stall;
    logic             in_fire;
    logic [WIDTH-1:0] in_win;

    // Global stall: every stage holds while the output waits for the consumer.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign in_fire  = in_valid && in_ready;

    // CLO is CLZ of the inverted operand.
    assign in_win = in_mode ? ~in_data : in_data;

    // Stages 0..L-2. Each stage looks at a window twice the size of the one it
    // keeps: if the upper half is all zero it adds the half-width to the count
    // and keeps the lower half, otherwise it keeps the upper half. Carrying
    // only the surviving half is equivalent to the shift-left formulation and
    // leaves no dead register bits.
    for (genvar k = 0; k < L - 1; k++) begin : g_stg
        localparam int             SW      = WIDTH >> k;
        localparam int             H       = SW / 2;
        localparam logic [L-1:0]   ACC_BIT = L'(1) << (L - 1 - k);

        logic [SW-1:0]    src_win;
        logic [L-1:0]     src_acc;
        logic [TAG_W-1:0] src_tag;
        logic             src_v;
        logic             upper_zero;

        logic             v_q;
        logic [H-1:0]     win_q;
        logic [L-1:0]     acc_q;
        logic [TAG_W-1:0] tag_q;

        if (k == 0) begin : g_head
            assign src_win = in_win;
            assign src_acc = '0;
            assign src_tag = in_tag;
            assign src_v   = in_fire;
        end else begin : g_body
            assign src_win = g_stg[k-1].win_q;
            assign src_acc = g_stg[k-1].acc_q;
            assign src_tag = g_stg[k-1].tag_q;
            assign src_v   = g_stg[k-1].v_q;
        end

        assign upper_zero = (src_win[SW-1 -: H] == '0);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                win_q <= '0;
                acc_q <= '0;
                tag_q <= '0;
            end else if (flush) begin
                v_q <= 1'b0;
            end else if (!stall) begin
                v_q <= src_v;
                // Data only moves with a valid operand, so bubbles never
                // disturb the held values.
                if (src_v) begin
                    win_q <= upper_zero ? src_win[H-1:0] : src_win[SW-1 -: H];
                    acc_q <= src_acc | (upper_zero ? ACC_BIT : '0);
                    tag_q <= src_tag;
                end
            end
        end
    end

    // Final stage: resolves the last count bit from a 2-bit window and
    // registers the result. The surviving bit says whether any counted-against
    // bit exists at all; if not, the count saturates to WIDTH.
    logic [1:0]       fin_win;
    logic [L-1:0]     fin_acc_in;
    logic [L-1:0]     fin_acc;
    logic [TAG_W-1:0] fin_tag;
    logic             fin_v;
    logic             fin_zero;
    logic             fin_b;

    assign fin_win    = g_stg[L-2].win_q;
    assign fin_acc_in = g_stg[L-2].acc_q;
    assign fin_tag    = g_stg[L-2].tag_q;
    assign fin_v      = g_stg[L-2].v_q;

    assign fin_zero = !fin_win[1];
    assign fin_b    = fin_zero ? fin_win[0] : fin_win[1];
    assign fin_acc  = fin_acc_in | {{(L-1){1'b0}}, fin_zero};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_all   <= 1'b0;
            out_tag   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_valid <= fin_v;
            if (fin_v) begin
                out_all   <= !fin_b;
                out_count <= fin_b ? {1'b0, fin_acc} : CW'(WIDTH);
                out_tag   <= fin_tag;
            end
        end
    end

endmodule
